// File: rtl/gpu_cmd_buffer.sv
// Command buffer between the external command pins and the layer header, palette and RAM write ports.
// Writes are queued and held back during a frame render. A single held read may bypass the queue while a render is active.
module gpu_cmd_buffer #(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int CMD_W  = 16,
  parameter int DATA_W = 16
) (
  input  logic              cmd_clk_in,
  input  logic              cmd_rst_n_in,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [CMD_W-1:0]  cmd_word,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              render_active,
  output logic              iss_valid,
  output logic              iss_write,
  output logic [CMD_W-1:0]  iss_cmd,
  output logic [DATA_W-1:0] iss_data,
  input  logic              iss_ready,
  input  logic              rsp_valid_in,
  input  logic [DATA_W-1:0] rsp_data_in,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              wr_pending,
  output logic [AW:0]       fifo_count,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, ISSUE_RD, WAIT_RSP, ISSUE_WR} state_t;

  state_t state, state_nxt;

  logic [CMD_W-1:0]  fifo_cmd  [DEPTH];
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;

  logic              rd_held;
  logic [CMD_W-1:0]  rd_held_cmd;
  logic              read_busy;

  logic push, rd_accept, load_rd, load_wr, iss_done, rsp_take;
  logic fifo_empty, fifo_full;

  assign fifo_full  = (count == (AW+1)'(DEPTH));
  assign fifo_empty = (count == '0);
  assign cmd_ready  = !fifo_full && !read_busy;
  assign push       = cmd_valid && cmd_ready && cmd_write;
  assign rd_accept  = cmd_valid && cmd_ready && !cmd_write;
  assign fifo_count = count;
  assign wr_pending = !fifo_empty || (iss_valid && iss_write);

  // Reads win in IDLE: during a render they bypass the queue, otherwise they wait for it to drain.
  always_comb begin
    state_nxt = state;
    load_rd   = 1'b0;
    load_wr   = 1'b0;
    iss_done  = 1'b0;
    rsp_take  = 1'b0;
    case (state)
      IDLE: begin
        if (rd_held && (render_active || (fifo_empty && !(iss_valid && iss_write)))) begin
          load_rd   = 1'b1;
          state_nxt = ISSUE_RD;
        end else if (!fifo_empty && !render_active) begin
          load_wr   = 1'b1;
          state_nxt = ISSUE_WR;
        end
      end
      ISSUE_RD: begin
        if (iss_ready) begin
          iss_done  = 1'b1;
          state_nxt = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (rsp_valid_in) begin
          rsp_take  = 1'b1;
          state_nxt = IDLE;
        end
      end
      ISSUE_WR: begin
        if (iss_ready) begin
          iss_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge cmd_clk_in or negedge cmd_rst_n_in) begin
    if (!cmd_rst_n_in) state <= IDLE;
    else               state <= state_nxt;
  end

  always_ff @(posedge cmd_clk_in) begin
    if (push) begin
      fifo_cmd[wr_ptr]  <= cmd_word;
      fifo_data[wr_ptr] <= cmd_data;
    end
  end

  always_ff @(posedge cmd_clk_in or negedge cmd_rst_n_in) begin
    if (!cmd_rst_n_in) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rd_held     <= 1'b0;
      rd_held_cmd <= '0;
      read_busy   <= 1'b0;
      iss_valid   <= 1'b0;
      iss_write   <= 1'b0;
      iss_cmd     <= '0;
      iss_data    <= '0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      overflow    <= 1'b0;
    end else begin
      rd_valid <= rsp_take;
      if (push)    wr_ptr <= wr_ptr + 1'b1;
      if (load_wr) rd_ptr <= rd_ptr + 1'b1;
      if (push && !load_wr)      count <= count + 1'b1;
      else if (!push && load_wr) count <= count - 1'b1;
      if (cmd_valid && !cmd_ready) overflow <= 1'b1;

      if (rd_accept) begin
        rd_held     <= 1'b1;
        rd_held_cmd <= cmd_word;
        read_busy   <= 1'b1;
      end else if (load_rd) begin
        rd_held <= 1'b0;
      end
      if (rsp_take) begin
        rd_data   <= rsp_data_in;
        read_busy <= 1'b0;
      end

      if (load_rd) begin
        iss_valid <= 1'b1;
        iss_write <= 1'b0;
        iss_cmd   <= rd_held_cmd;
        iss_data  <= '0;
      end else if (load_wr) begin
        iss_valid <= 1'b1;
        iss_write <= 1'b1;
        iss_cmd   <= fifo_cmd[rd_ptr];
        iss_data  <= fifo_data[rd_ptr];
      end else if (iss_done) begin
        iss_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gpu_cmd_buffer.sv
// Directed bench for gpu_cmd_buffer: scoreboard of expected issues and read results plus a downstream memory responder.
module tb_gpu_cmd_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_word, cmd_data;
  logic        render_active;
  logic        iss_valid, iss_write, iss_ready;
  logic [15:0] iss_cmd, iss_data;
  logic        rsp_valid_in;
  logic [15:0] rsp_data_in;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        wr_pending;
  logic [4:0]  fifo_count;
  logic        overflow;

  gpu_cmd_buffer #(.DEPTH(16), .AW(4), .CMD_W(16), .DATA_W(16)) dut (
    .cmd_clk_in(clk), .cmd_rst_n_in(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_word(cmd_word), .cmd_data(cmd_data), .render_active(render_active),
    .iss_valid(iss_valid), .iss_write(iss_write), .iss_cmd(iss_cmd),
    .iss_data(iss_data), .iss_ready(iss_ready),
    .rsp_valid_in(rsp_valid_in), .rsp_data_in(rsp_data_in),
    .rd_valid(rd_valid), .rd_data(rd_data), .wr_pending(wr_pending),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [15:0] cmd;
    logic [15:0] data;
  } iss_t;

  iss_t        exp_iss [$];
  logic [15:0] exp_rd  [$];
  logic [15:0] dmem    [logic [15:0]];

  int          checks = 0;
  int          errors = 0;
  int          rsp_cnt = 0;
  logic [15:0] rsp_addr = '0;
  logic        auto_rsp, manual_rsp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs at a falling edge after inputs for the coming cycle are set, then advances one cycle.
  task automatic tick();
    iss_t e;
    if (rst_n) begin
      rsp_valid_in = 1'b0;
      if (manual_rsp) begin
        rsp_valid_in = 1'b1;
        rsp_data_in  = 16'hDEAD;
      end
      if (rsp_cnt != 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          rsp_valid_in = 1'b1;
          rsp_data_in  = dmem.exists(rsp_addr) ? dmem[rsp_addr] : 16'h0000;
        end
      end
      if (rd_valid) begin
        if (exp_rd.size() == 0) check("rd_unexpected", 32'(rd_valid), 32'd0);
        else                    check("rd_data", 32'(rd_data), 32'(exp_rd.pop_front()));
      end
      if (iss_valid && iss_ready) begin
        if (exp_iss.size() == 0) begin
          check("iss_unexpected", 32'(iss_valid), 32'd0);
        end else begin
          e = exp_iss.pop_front();
          check("iss_write", 32'(iss_write), 32'(e.w));
          check("iss_cmd", 32'(iss_cmd), 32'(e.cmd));
          if (e.w) check("iss_data", 32'(iss_data), 32'(e.data));
        end
        if (iss_write) dmem[iss_cmd] = iss_data;
        else if (auto_rsp) begin
          rsp_addr = iss_cmd;
          rsp_cnt  = 2;
        end
      end
    end else begin
      rsp_valid_in = 1'b0;
      rsp_cnt      = 0;
    end
    @(negedge clk);
  endtask

  task automatic send(input logic w, input logic [15:0] word, input logic [15:0] data);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_word  = word;
    cmd_data  = data;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic push_iss(input logic w, input logic [15:0] word, input logic [15:0] data);
    iss_t e;
    e.w = w; e.cmd = word; e.data = data;
    exp_iss.push_back(e);
  endtask

  task automatic drain(input string tag, input int unsigned max, input logic rd_only);
    for (int unsigned i = 0; i < max && (exp_rd.size() != 0 || (!rd_only && exp_iss.size() != 0)); i++)
      tick();
    check(tag, 32'(exp_rd.size() + (rd_only ? 0 : exp_iss.size())), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_word = '0; cmd_data = '0;
    render_active = 1'b0; iss_ready = 1'b0; rsp_valid_in = 1'b0; rsp_data_in = '0;
    auto_rsp = 1'b1; manual_rsp = 1'b0;

    // Reset and idle
    repeat (2) @(negedge clk);
    check("rst_iss_valid", 32'(iss_valid), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    rst_n = 1'b1;
    tick(); tick();
    check("idle_iss_valid", 32'(iss_valid), 32'd0);
    check("idle_rd_valid", 32'(rd_valid), 32'd0);
    check("idle_rd_data", 32'(rd_data), 32'd0);
    check("idle_wr_pending", 32'(wr_pending), 32'd0);
    check("idle_overflow", 32'(overflow), 32'd0);
    check("idle_fifo_count", 32'(fifo_count), 32'd0);
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // Plain write, two-cycle issue latency
    iss_ready = 1'b1;
    push_iss(1'b1, 16'h0305, 16'h8410);
    send(1'b1, 16'h0305, 16'h8410);
    check("lat_n1_iss_valid", 32'(iss_valid), 32'd0);
    check("lat_n1_fifo_count", 32'(fifo_count), 32'd1);
    check("lat_n1_wr_pending", 32'(wr_pending), 32'd1);
    tick();
    check("lat_n2_iss_valid", 32'(iss_valid), 32'd1);
    check("lat_n2_wr_pending", 32'(wr_pending), 32'd1);
    tick();
    check("post_hs_wr_pending", 32'(wr_pending), 32'd0);
    check("post_hs_iss_valid", 32'(iss_valid), 32'd0);

    // Read bypasses a queued write during render and sees the old value
    render_active = 1'b1;
    push_iss(1'b0, 16'h0305, 16'h0000);
    push_iss(1'b1, 16'h0305, 16'h07E0);
    exp_rd.push_back(16'h8410);
    send(1'b1, 16'h0305, 16'h07E0);
    send(1'b0, 16'h0305, 16'h0000);
    check("rd_busy_cmd_ready", 32'(cmd_ready), 32'd0);
    drain("bypass_rd_done", 20, 1'b1);
    check("bypass_fifo_count", 32'(fifo_count), 32'd1);
    check("bypass_wr_pending", 32'(wr_pending), 32'd1);
    check("bypass_wr_held", 32'(iss_valid), 32'd0);
    render_active = 1'b0;
    drain("bypass_wr_done", 20, 1'b0);
    check("bypass_end_fifo", 32'(fifo_count), 32'd0);

    // Read waits behind an unaccepted write and sees the new value
    iss_ready = 1'b0;
    push_iss(1'b1, 16'h0001, 16'h1111);
    push_iss(1'b0, 16'h0001, 16'h0000);
    exp_rd.push_back(16'h1111);
    send(1'b1, 16'h0001, 16'h1111);
    send(1'b0, 16'h0001, 16'h0000);
    repeat (4) tick();
    check("raw_stall_valid", 32'(iss_valid), 32'd1);
    check("raw_stall_write", 32'(iss_write), 32'd1);
    check("raw_stall_cmd", 32'(iss_cmd), 32'h0001);
    check("raw_stall_ready", 32'(cmd_ready), 32'd0);
    iss_ready = 1'b1;
    drain("raw_done", 30, 1'b0);

    // Fill to DEPTH with wrapped pointers, overflow, then drain in order
    iss_ready = 1'b0;
    render_active = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push_iss(1'b1, 16'h0100 + 16'(i), 16'hA000 + 16'(i));
      send(1'b1, 16'h0100 + 16'(i), 16'hA000 + 16'(i));
    end
    check("full_fifo_count", 32'(fifo_count), 32'd16);
    check("full_cmd_ready", 32'(cmd_ready), 32'd0);
    check("full_overflow_pre", 32'(overflow), 32'd0);
    send(1'b1, 16'h0FFF, 16'hFFFF);
    check("full_overflow", 32'(overflow), 32'd1);
    check("full_fifo_after_ovf", 32'(fifo_count), 32'd16);
    render_active = 1'b0;
    iss_ready = 1'b1;
    drain("full_drain", 100, 1'b0);
    check("drain_fifo_count", 32'(fifo_count), 32'd0);
    check("drain_wr_pending", 32'(wr_pending), 32'd0);
    check("overflow_sticky", 32'(overflow), 32'd1);

    // Reset while waiting for a read response with writes queued
    render_active = 1'b1;
    auto_rsp = 1'b0;
    for (int i = 0; i < 5; i++) send(1'b1, 16'h0200 + 16'(i), 16'hB000 + 16'(i));
    push_iss(1'b0, 16'h0305, 16'h0000);
    send(1'b0, 16'h0305, 16'h0000);
    drain("wait_rsp_issued", 20, 1'b0);
    tick(); tick();
    check("pre_rst_fifo_count", 32'(fifo_count), 32'd5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_iss_valid", 32'(iss_valid), 32'd0);
    check("mid_rst_fifo_count", 32'(fifo_count), 32'd0);
    check("mid_rst_wr_pending", 32'(wr_pending), 32'd0);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    manual_rsp = 1'b1;
    tick();
    manual_rsp = 1'b0;
    render_active = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_rd_valid", 32'(rd_valid), 32'd0);
      check("post_rst_iss_valid", 32'(iss_valid), 32'd0);
    end
    check("post_rst_rd_data", 32'(rd_data), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
